ms_timer_sched: RTL and testbench

//  Shared 1 ms timebase plus N independent millisecond countdown timers for the heart-rate path
//  (RR-interval timeout, refractory window, asystole alarm, display refresh).

---
 rtl/ms_timer_pkg.sv | 27 ++
 rtl/ms_timer_if.sv | 34 +++
 rtl/ms_timer_channel.sv | 104 ++++++++++
 rtl/ms_timer_sched.sv | 92 +++++++++
 tb/tb_ms_timer_sched.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ms_timer_pkg.sv
// ----------------------------------------------------------------------------
// ms_timer_pkg
// Shared types and helpers for the millisecond timer scheduler.
//   ch_state_t     : per-channel FSM state (CH_IDLE / CH_RUN)
//   DEFAULT_CNT_W  : default width of period / remain values in ms
//   calc_div()     : system clocks per tick (CLK_HZ / TICK_HZ)
//   calc_div_w()   : width of the prescaler counter, $clog2(DIV)
// ----------------------------------------------------------------------------
package ms_timer_pkg;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    localparam int DEFAULT_CNT_W = 12;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // DIV is at least 2, so the counter always has at least one bit.
    function automatic int calc_div_w(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/ms_timer_if.sv
// ----------------------------------------------------------------------------
// ms_timer_if
// Requester-side bundle of the timer scheduler. Channel i occupies bit i of
// the per-channel vectors and bits [i*CNT_W +: CNT_W] of period / remain.
//   start  : per-channel start/restart pulse         (master -> slave)
//   mode   : 1 = periodic, 0 = one-shot              (master -> slave)
//   period : reload value in ms                      (master -> slave)
//   cancel : per-channel stop pulse                  (master -> slave)
//   busy   : channel is running                      (slave -> master)
//   expire : one-cycle expiry pulse                  (slave -> master)
//   remain : remaining ms                            (slave -> master)
// ----------------------------------------------------------------------------
interface ms_timer_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 12
);
    logic [N_CH-1:0]       start;
    logic [N_CH-1:0]       mode;
    logic [N_CH*CNT_W-1:0] period;
    logic [N_CH-1:0]       cancel;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       expire;
    logic [N_CH*CNT_W-1:0] remain;

    modport master (
        output start, mode, period, cancel,
        input  busy, expire, remain
    );

    modport slave (
        input  start, mode, period, cancel,
        output busy, expire, remain
    );
endinterface

// File: rtl/ms_timer_channel.sv
// ----------------------------------------------------------------------------
// ms_timer_channel
// One millisecond countdown channel: IDLE/RUN FSM plus remain counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : one-cycle timebase enable (already gated by en/pause)
//   start      : start/restart pulse, loads period
//   mode       : 1 = periodic, 0 = one-shot; sampled at start and reload
//   period     : reload value in ms
//   cancel     : stop pulse, highest priority, never produces an expire
//   busy       : channel in RUN
//   expire     : one-cycle expiry pulse
//   remain     : remaining ms (0 when idle)
// Priority per cycle: cancel > start > tick.
// ----------------------------------------------------------------------------
module ms_timer_channel
    import ms_timer_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] period,
    input  logic             cancel,
    output logic             busy,
    output logic             expire,
    output logic [CNT_W-1:0] remain
);

    ch_state_t        state_q,  state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic             expire_q, expire_d;
    logic             mode_q,   mode_d;

    // State register: all outputs come straight from flops.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CH_IDLE;
            remain_q <= '0;
            expire_q <= 1'b0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            expire_q <= expire_d;
            mode_q   <= mode_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // branches below can leave one unassigned and infer a latch.
        state_d  = state_q;
        remain_d = remain_q;
        expire_d = 1'b0;
        mode_d   = mode_q;

        if (cancel) begin
            // Silent stop, even when a tick would expire this very cycle.
            state_d  = CH_IDLE;
            remain_d = '0;
        end else if (start) begin
            if (period != '0) begin
                // Restart drops any tick pending this cycle.
                state_d  = CH_RUN;
                remain_d = period;
                mode_d   = mode;
            end else begin
                // Zero period expires immediately without ever running.
                state_d  = CH_IDLE;
                remain_d = '0;
                expire_d = 1'b1;
            end
        end else if (state_q == CH_RUN && tick) begin
            if (remain_q > CNT_W'(1)) begin
                remain_d = remain_q - CNT_W'(1);
            end else begin
                expire_d = 1'b1;
                if (mode_q && period != '0) begin
                    // Periodic reload picks up the period present right now.
                    remain_d = period;
                    mode_d   = mode;
                end else begin
                    state_d  = CH_IDLE;
                    remain_d = '0;
                end
            end
        end
    end

    // Output logic.
    always_comb begin
        busy   = (state_q == CH_RUN);
        expire = expire_q;
        remain = remain_q;
    end

endmodule

// File: rtl/ms_timer_sched.sv
// ----------------------------------------------------------------------------
// ms_timer_sched
// Shared 1 ms timebase plus N_CH independent millisecond countdown timers.
// A free-running prescaler produces a one-cycle tick_ms enable every DIV
// clocks (no divided clock); each channel counts down on that tick.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : global timebase enable; 0 clears the prescaler, freezes channels
//   pause      : (only with MSTMR_PAUSE_EN) holds the prescaler phase,
//                freezes channels; start/cancel keep working
//   tick_ms    : one-cycle pulse every DIV cycles
//   bus        : ms_timer_if.slave, per-channel start/mode/period/cancel in,
//                busy/expire/remain out
// Configuration macro: MSTMR_PAUSE_EN adds the pause input.
// ----------------------------------------------------------------------------
module ms_timer_sched
    import ms_timer_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int N_CH    = 4,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
`ifdef MSTMR_PAUSE_EN
    input  logic        pause,
`endif
    output logic        tick_ms,
    ms_timer_if.slave   bus
);

    localparam int               DIV   = calc_div(CLK_HZ, TICK_HZ);
    localparam int               DIV_W = calc_div_w(DIV);
    localparam logic [DIV_W-1:0] LAST  = DIV_W'(DIV - 1);

    logic             hold;
    logic [DIV_W-1:0] pre_cnt;
    logic             ch_tick;

`ifdef MSTMR_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // Prescaler: tick_ms is registered, high in the cycle after pre_cnt==DIV-1.
    // Pause keeps the phase so a partial millisecond is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            tick_ms <= 1'b0;
        end else if (!en) begin
            pre_cnt <= '0;
            tick_ms <= 1'b0;
        end else if (hold) begin
            tick_ms <= 1'b0;
        end else begin
            tick_ms <= (pre_cnt == LAST);
            pre_cnt <= (pre_cnt == LAST) ? '0 : pre_cnt + DIV_W'(1);
        end
    end

    // A tick already registered must not leak into channels once the
    // timebase is stopped, so it is also gated with the current controls.
    assign ch_tick = tick_ms & en & ~hold;

    logic [N_CH-1:0]       busy_v;
    logic [N_CH-1:0]       expire_v;
    logic [N_CH*CNT_W-1:0] remain_v;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ms_timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (ch_tick),
            .start  (bus.start[i]),
            .mode   (bus.mode[i]),
            .period (bus.period[i*CNT_W +: CNT_W]),
            .cancel (bus.cancel[i]),
            .busy   (busy_v[i]),
            .expire (expire_v[i]),
            .remain (remain_v[i*CNT_W +: CNT_W])
        );
    end

    assign bus.busy   = busy_v;
    assign bus.expire = expire_v;
    assign bus.remain = remain_v;

endmodule

// File: tb/tb_ms_timer_sched.sv
// ----------------------------------------------------------------------------
// tb_ms_timer_sched
// Self-checking bench for ms_timer_sched with CLK_HZ=10_000, TICK_HZ=1000
// (DIV=10), N_CH=4. Time t counts clock edges since the timebase was enabled;
// tick_ms is expected high in the cycle after every edge where t%10==0.
// ----------------------------------------------------------------------------
module tb_ms_timer_sched;
    import ms_timer_pkg::*;

    localparam int CLK_HZ  = 10_000;
    localparam int TICK_HZ = 1000;
    localparam int N_CH    = 4;
    localparam int CNT_W   = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
`ifdef MSTMR_PAUSE_EN
    logic pause = 1'b0;
`endif
    logic tick_ms;

    ms_timer_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    ms_timer_sched #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ),
        .N_CH   (N_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
`ifdef MSTMR_PAUSE_EN
        .pause  (pause),
`endif
        .tick_ms(tick_ms),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int t     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    // Advance n edges; outputs are then sampled 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    function automatic logic [47:0] pk(input int r3, input int r2, input int r1, input int r0);
        return {12'(r3), 12'(r2), 12'(r1), 12'(r0)};
    endfunction

    task automatic wait_expire(input int ch, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.expire[ch]) begin
                found = 1'b1;
                return;
            end
            step(1);
        end
    endtask

    typedef struct {
        int          adv;
        logic [3:0]  start;
        logic [3:0]  cancel;
        logic [3:0]  mode;
        logic [47:0] period;
        logic        exp_tick;
        logic [3:0]  exp_busy;
        logic [3:0]  exp_expire;
        logic [47:0] exp_remain;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, t=%0d", t);
        $fatal(1);
    end

    initial begin
        bit ok;
        int last;

        bus.start  = '0;
        bus.cancel = '0;
        bus.mode   = '0;
        bus.period = '0;

        // ---------- table: ch0 one-shot P=3 (t=36..62), ch3 zero period,
        // restart on a tick, cancel, start+cancel (t=63..83)
        vecs[0]  = '{1,  4'b0001, 4'b0000, 4'b0000, pk(0,0,0,3), 1'b0, 4'b0001, 4'b0000, pk(0,0,0,3)};
        vecs[1]  = '{4,  4'b0000, 4'b0000, 4'b0000, pk(0,0,0,3), 1'b1, 4'b0001, 4'b0000, pk(0,0,0,3)};
        vecs[2]  = '{1,  4'b0000, 4'b0000, 4'b0000, pk(0,0,0,3), 1'b0, 4'b0001, 4'b0000, pk(0,0,0,2)};
        vecs[3]  = '{10, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,3), 1'b0, 4'b0001, 4'b0000, pk(0,0,0,1)};
        vecs[4]  = '{9,  4'b0000, 4'b0000, 4'b0000, pk(0,0,0,3), 1'b1, 4'b0001, 4'b0000, pk(0,0,0,1)};
        vecs[5]  = '{1,  4'b0000, 4'b0000, 4'b0000, pk(0,0,0,3), 1'b0, 4'b0000, 4'b0001, pk(0,0,0,0)};
        vecs[6]  = '{1,  4'b0000, 4'b0000, 4'b0000, pk(0,0,0,3), 1'b0, 4'b0000, 4'b0000, pk(0,0,0,0)};
        vecs[7]  = '{1,  4'b1000, 4'b0000, 4'b0000, pk(0,0,0,3), 1'b0, 4'b0000, 4'b1000, pk(0,0,0,0)};
        vecs[8]  = '{1,  4'b0000, 4'b0000, 4'b0000, pk(0,0,0,3), 1'b0, 4'b0000, 4'b0000, pk(0,0,0,0)};
        vecs[9]  = '{1,  4'b1000, 4'b0000, 4'b0000, pk(3,0,0,3), 1'b0, 4'b1000, 4'b0000, pk(3,0,0,0)};
        vecs[10] = '{6,  4'b0000, 4'b0000, 4'b0000, pk(3,0,0,3), 1'b0, 4'b1000, 4'b0000, pk(2,0,0,0)};
        vecs[11] = '{9,  4'b0000, 4'b0000, 4'b0000, pk(3,0,0,3), 1'b1, 4'b1000, 4'b0000, pk(2,0,0,0)};
        vecs[12] = '{1,  4'b1000, 4'b0000, 4'b0000, pk(5,0,0,3), 1'b0, 4'b1000, 4'b0000, pk(5,0,0,0)};
        vecs[13] = '{1,  4'b0000, 4'b1000, 4'b0000, pk(5,0,0,3), 1'b0, 4'b0000, 4'b0000, pk(0,0,0,0)};
        vecs[14] = '{1,  4'b0100, 4'b0100, 4'b0000, pk(5,7,0,3), 1'b0, 4'b0000, 4'b0000, pk(0,0,0,0)};

        // ---------- reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2);
        check("rst tick",   tick_ms,    1'b0);
        check("rst busy",   bus.busy,   4'b0);
        check("rst expire", bus.expire, 4'b0);
        check("rst remain", bus.remain, 48'b0);

        // ---------- timebase: tick at t = 10, 20, 30
        en = 1'b1;
        t  = 0;
        for (int k = 1; k <= 35; k++) begin
            step(1);
            check($sformatf("tick t%0d", k), tick_ms, (k % 10 == 0));
        end
        check("idle busy",   bus.busy,   4'b0);
        check("idle expire", bus.expire, 4'b0);

        // ---------- table-driven vectors
        foreach (vecs[i]) begin
            bus.start  = vecs[i].start;
            bus.cancel = vecs[i].cancel;
            bus.mode   = vecs[i].mode;
            bus.period = vecs[i].period;
            step(1);
            bus.start  = '0;
            bus.cancel = '0;
            step(vecs[i].adv - 1);
            check($sformatf("vec%0d tick",   i), tick_ms,    vecs[i].exp_tick);
            check($sformatf("vec%0d busy",   i), bus.busy,   vecs[i].exp_busy);
            check($sformatf("vec%0d expire", i), bus.expire, vecs[i].exp_expire);
            check($sformatf("vec%0d remain", i), bus.remain, vecs[i].exp_remain);
        end

        // ---------- ch1 periodic P=2 started at t=84; period -> 4 after 5th expiry
        bus.mode   = 4'b0010;
        bus.period = pk(0,0,2,0);
        bus.start  = 4'b0010;
        step(1);
        bus.start  = '0;
        check("per start remain", bus.remain[CNT_W +: CNT_W], 12'd2);
        last = t;
        for (int k = 1; k <= 7; k++) begin
            wait_expire(1, 60, ok);
            if (!ok) begin
                check($sformatf("per exp%0d timeout", k), 1'b0, 1'b1);
                break;
            end
            if (k == 1)      check("per first expire t", t, 101);
            else if (k <= 6) check($sformatf("per gap%0d", k), t - last, 20);
            else             check($sformatf("per gap%0d", k), t - last, 40);
            check($sformatf("per busy%0d", k), bus.busy[1], 1'b1);
            last = t;
            if (k == 5) bus.period = pk(0,0,4,0);
            step(1);
            check($sformatf("per pulse%0d", k), bus.expire[1], 1'b0);
        end
        bus.cancel = 4'b0010;
        step(1);
        bus.cancel = '0;
        check("per cancel busy", bus.busy[1], 1'b0);

        // ---------- cancel coinciding with expiring tick (ch2 P=2 from t=244)
        bus.mode   = '0;
        bus.period = pk(0,2,0,0);
        bus.start  = 4'b0100;
        step(1);
        bus.start  = '0;
        check("cx start remain", bus.remain[2*CNT_W +: CNT_W], 12'd2);
        step(16);
        check("cx tick",   tick_ms, 1'b1);
        check("cx remain1", bus.remain[2*CNT_W +: CNT_W], 12'd1);
        bus.cancel = 4'b0100;
        step(1);
        bus.cancel = '0;
        check("cx busy",   bus.busy[2],   1'b0);
        check("cx remain", bus.remain[2*CNT_W +: CNT_W], 12'd0);
        check("cx expire", bus.expire[2], 1'b0);
        step(1);
        check("cx expire late", bus.expire[2], 1'b0);

        // ---------- en=0 freeze (ch0 P=5 from t=263)
        bus.period = pk(0,0,0,5);
        bus.start  = 4'b0001;
        step(1);
        bus.start  = '0;
        step(20);
        check("frz pre remain", bus.remain[0 +: CNT_W], 12'd3);
        en = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step(1);
            check("frz remain", bus.remain[0 +: CNT_W], 12'd3);
            check("frz tick",   tick_ms, 1'b0);
        end
        en = 1'b1;
        step(9);
        check("frz resume hold", bus.remain[0 +: CNT_W], 12'd3);
        step(1);
        check("frz resume tick", tick_ms, 1'b1);
        step(1);
        check("frz resume dec", bus.remain[0 +: CNT_W], 12'd2);
        check("frz resume busy", bus.busy[0], 1'b1);

        // ---------- asynchronous reset mid-run
        #2;
        rst_n = 1'b0;
        #1;
        check("arst busy",   bus.busy,   4'b0);
        check("arst remain", bus.remain, 48'b0);
        check("arst tick",   tick_ms,    1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        t = 0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("arst no expire", bus.expire, 4'b0);
        end

`ifdef MSTMR_PAUSE_EN
        // ---------- pause at pre_cnt=4 (t=4), release at t=11 -> tick at t=17
        pause = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step(1);
            check("pause tick", tick_ms, 1'b0);
        end
        pause = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            check($sformatf("pause rel%0d", k), tick_ms, (k == 6));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
